// File: rtl/decade_chain_ctrl_if.sv
// ============================================================================
//  decade_chain_ctrl_if
//  Command, limit and BCD count bundle between the control side and decade_chain_ctrl.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface decade_chain_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  stop;
    logic                  clear;
    logic [4*DIGITS-1:0]   limit;
    logic [4*DIGITS-1:0]   cnt;
    logic [DIGITS-1:0]     dig_en;
    logic                  running;
    logic                  done;

    modport master (
        output start, stop, clear, limit,
        input  cnt, dig_en, running, done
    );

    modport slave (
        input  start, stop, clear, limit,
        output cnt, dig_en, running, done
    );
endinterface

`default_nettype wire

// File: rtl/decade_chain_ctrl.sv
// ============================================================================
//  decade_chain_ctrl
//  Multi-digit BCD counter with prescaler, start/stop/clear FSM and terminal stop.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module decade_chain_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    decade_chain_ctrl_if.slave bus
);
    localparam int            PW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int            CW          = 4 * DIGITS;
    localparam logic [PW-1:0] C_PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   limit_q, limit_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            done_q, done_d;

    logic            w_tick;
    logic [DIGITS-1:0] w_dig_en;
    logic [CW-1:0]   w_cnt_inc;

    assign w_tick = (state_q == ST_RUN) && (presc_q == C_PRESC_MAX);

    // Carry is a pure AND chain over current digit values, so every digit
    // that rolls over updates on the same edge as digit 0.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        if (gi == 0) begin : g_lsd
            assign w_dig_en[gi] = w_tick;
        end else begin : g_upper
            assign w_dig_en[gi] = w_dig_en[gi-1] && (cnt_q[4*gi-1 -: 4] == 4'd9);
        end
        assign w_cnt_inc[4*gi +: 4] = !w_dig_en[gi]                  ? cnt_q[4*gi +: 4] :
                                      (cnt_q[4*gi +: 4] >= 4'd9)     ? 4'd0 :
                                                                       cnt_q[4*gi +: 4] + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            limit_q <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        presc_d = presc_q;
        done_d  = 1'b0;

        if (bus.clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            presc_d = '0;
        end else if (bus.stop && (state_q == ST_RUN)) begin
            state_d = ST_PAUSE;
        end else if (bus.start && (state_q != ST_RUN)) begin
            state_d = ST_RUN;
            if (state_q == ST_IDLE) begin
                limit_d = bus.limit;
            end else if (state_q == ST_DONE) begin
                cnt_d   = '0;
                presc_d = '0;
                limit_d = bus.limit;
            end
        end else if (state_q == ST_RUN) begin
            presc_d = (presc_q == C_PRESC_MAX) ? '0 : presc_q + PW'(1);
            if (w_tick) begin
                cnt_d = w_cnt_inc;
                // A limit holding a non-decimal digit can never match, so it free-runs.
                if ((limit_q != '0) && (w_cnt_inc == limit_q)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    assign bus.cnt     = cnt_q;
    assign bus.dig_en  = w_dig_en;
    assign bus.running = (state_q == ST_RUN);
    assign bus.done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_decade_chain_ctrl.sv
// ============================================================================
//  tb_decade_chain_ctrl
//  Two-digit instances (prescale 1 and 3) checked against a decimal reference model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_decade_chain_ctrl;
    localparam int D = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       st [2];
    logic       sp [2];
    logic       cl [2];
    logic [7:0] lm [2];

    decade_chain_ctrl_if #(.DIGITS(D)) bus1 ();
    decade_chain_ctrl_if #(.DIGITS(D)) bus3 ();

    assign bus1.start = st[0];
    assign bus1.stop  = sp[0];
    assign bus1.clear = cl[0];
    assign bus1.limit = lm[0];
    assign bus3.start = st[1];
    assign bus3.stop  = sp[1];
    assign bus3.clear = cl[1];
    assign bus3.limit = lm[1];

    decade_chain_ctrl #(.DIGITS(D), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    decade_chain_ctrl #(.DIGITS(D), .PRESCALE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // Reference model: count kept as a plain decimal integer 0..99.
    int PS [2] = '{1, 3};
    int m_state [2];
    int m_val   [2];
    int m_ph    [2];
    int m_lim   [2];
    bit m_done  [2];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int bcd2int(input logic [7:0] b);
        if (b[3:0] > 4'd9 || b[7:4] > 4'd9) return -1;
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] cnt_of(input int i);
        return (i == 0) ? bus1.cnt : bus3.cnt;
    endfunction
    function automatic logic run_of(input int i);
        return (i == 0) ? bus1.running : bus3.running;
    endfunction
    function automatic logic done_of(input int i);
        return (i == 0) ? bus1.done : bus3.done;
    endfunction
    function automatic logic [1:0] en_of(input int i);
        return (i == 0) ? bus1.dig_en : bus3.dig_en;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = M_IDLE; m_val[i] = 0; m_ph[i] = 0; m_lim[i] = 0; m_done[i] = 0;
        end
    endtask

    task automatic model_update(input int i);
        bit tick;
        m_done[i] = 0;
        if (cl[i]) begin
            m_state[i] = M_IDLE; m_val[i] = 0; m_ph[i] = 0;
        end else if (sp[i] && m_state[i] == M_RUN) begin
            m_state[i] = M_PAUSE;
        end else if (st[i] && m_state[i] != M_RUN) begin
            if (m_state[i] == M_IDLE) m_lim[i] = bcd2int(lm[i]);
            if (m_state[i] == M_DONE) begin
                m_val[i] = 0; m_ph[i] = 0; m_lim[i] = bcd2int(lm[i]);
            end
            m_state[i] = M_RUN;
        end else if (m_state[i] == M_RUN) begin
            tick = (m_ph[i] == PS[i] - 1);
            m_ph[i] = (m_ph[i] + 1) % PS[i];
            if (tick) begin
                m_val[i] = (m_val[i] + 1) % 100;
                if (m_lim[i] > 0 && m_val[i] == m_lim[i]) begin
                    m_state[i] = M_DONE; m_done[i] = 1;
                end
            end
        end
    endtask

    task automatic step();
        for (int i = 0; i < 2; i++) begin
            bit tick;
            tick = (m_state[i] == M_RUN) && (m_ph[i] == PS[i] - 1);
            chk($sformatf("dig_en[u%0d]", i), 32'(en_of(i)),
                32'({tick && (m_val[i] % 10 == 9), tick}));
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_update(i);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("cnt[u%0d]", i),     32'(cnt_of(i)), 32'(int2bcd(m_val[i])));
            chk($sformatf("running[u%0d]", i), 32'(run_of(i)), 32'(m_state[i] == M_RUN));
            chk($sformatf("done[u%0d]", i),    32'(done_of(i)), 32'(m_done[i]));
        end
    endtask

    task automatic quiet();
        for (int i = 0; i < 2; i++) begin st[i] = 0; sp[i] = 0; cl[i] = 0; end
    endtask

    typedef struct {
        bit         start, stop, clear;
        logic [7:0] limit;
        logic [7:0] cnt;
        bit         running, done;
    } vec_t;

    task automatic run_free(input logic [7:0] lim);
        int ndone = 0;
        quiet(); cl[0] = 1; step();
        quiet(); st[0] = 1; lm[0] = lim; step();
        quiet();
        for (int n = 0; n < 100; n++) begin
            step();
            if (bus1.done) ndone++;
        end
        chk("freerun_wrap_cnt", 32'(bus1.cnt), 32'h00);
        chk("freerun_no_done", ndone, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [14];
        tv[0]  = '{1, 0, 0, 8'h03, 8'h00, 1, 0};
        tv[1]  = '{0, 0, 0, 8'h03, 8'h01, 1, 0};
        tv[2]  = '{0, 0, 0, 8'h03, 8'h02, 1, 0};
        tv[3]  = '{0, 0, 0, 8'h03, 8'h03, 0, 1};
        tv[4]  = '{0, 0, 0, 8'h03, 8'h03, 0, 0};
        tv[5]  = '{1, 0, 0, 8'h02, 8'h00, 1, 0};
        tv[6]  = '{1, 1, 0, 8'h02, 8'h00, 0, 0};
        tv[7]  = '{1, 0, 0, 8'h02, 8'h00, 1, 0};
        tv[8]  = '{0, 0, 0, 8'h02, 8'h01, 1, 0};
        tv[9]  = '{1, 0, 1, 8'h02, 8'h00, 0, 0};
        tv[10] = '{1, 0, 0, 8'h9A, 8'h00, 1, 0};
        tv[11] = '{0, 0, 0, 8'h9A, 8'h01, 1, 0};
        tv[12] = '{0, 1, 0, 8'h9A, 8'h01, 0, 0};
        tv[13] = '{0, 1, 0, 8'h9A, 8'h01, 0, 0};

        quiet(); lm[0] = 8'h00; lm[1] = 8'h00;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_cnt", 32'(cnt_of(i)), 0);
            chk("reset_running", 32'(run_of(i)), 0);
            chk("reset_done", 32'(done_of(i)), 0);
            chk("reset_dig_en", 32'(en_of(i)), 0);
        end
        rst = 1'b0;

        // Directed vector table on the prescale-1 unit
        for (int v = 0; v < 14; v++) begin
            st[0] = tv[v].start; sp[0] = tv[v].stop; cl[0] = tv[v].clear; lm[0] = tv[v].limit;
            step();
            chk($sformatf("vec%0d_cnt", v), 32'(bus1.cnt), 32'(tv[v].cnt));
            chk($sformatf("vec%0d_running", v), 32'(bus1.running), 32'(tv[v].running));
            chk($sformatf("vec%0d_done", v), 32'(bus1.done), 32'(tv[v].done));
        end

        // Free-run wrap, zero limit and unreachable limit
        run_free(8'h00);
        run_free(8'h0A);

        // Limit latched only at start
        begin
            bit seen = 0;
            quiet(); cl[0] = 1; step();
            quiet(); st[0] = 1; lm[0] = 8'h05; step();
            quiet(); lm[0] = 8'h03;
            for (int n = 0; n < 20 && !seen; n++) begin
                step();
                if (bus1.done) begin
                    seen = 1;
                    chk("latched_limit_cnt", 32'(bus1.cnt), 32'h05);
                end
            end
            chk("latched_limit_done_seen", 32'(seen), 1);
        end

        // Prescale 3, terminal 0x25
        quiet(); cl[0] = 1; cl[1] = 1; step();
        quiet(); st[1] = 1; lm[1] = 8'h25; step();
        quiet();
        step(); step();
        chk("p3_before_first_tick", 32'(bus3.cnt), 32'h00);
        step();
        chk("p3_first_tick_k3", 32'(bus3.cnt), 32'h01);
        repeat (71) step();
        chk("p3_pre_terminal", 32'(bus3.done), 0);
        step();
        chk("p3_terminal_cnt_k75", 32'(bus3.cnt), 32'h25);
        chk("p3_terminal_done", 32'(bus3.done), 1);
        chk("p3_terminal_running", 32'(bus3.running), 0);
        for (int n = 0; n < 20; n++) begin
            step();
            chk("p3_done_hold_cnt", 32'(bus3.cnt), 32'h25);
            chk("p3_done_hold_done", 32'(bus3.done), 0);
        end

        // Pause / resume at 0x12
        quiet(); cl[1] = 1; step();
        quiet(); st[1] = 1; lm[1] = 8'h00; step();
        quiet();
        for (int n = 0; n < 60 && bus3.cnt != 8'h12; n++) step();
        chk("pause_reached_12", 32'(bus3.cnt), 32'h12);
        sp[1] = 1; step(); quiet();
        repeat (10) step();
        chk("pause_hold_cnt", 32'(bus3.cnt), 32'h12);
        chk("pause_running", 32'(bus3.running), 0);
        st[1] = 1; step(); quiet();
        step(); step();
        chk("resume_not_yet", 32'(bus3.cnt), 32'h12);
        step();
        chk("resume_3clk", 32'(bus3.cnt), 32'h13);

        // Command priority in RUN on the prescale-3 unit
        st[1] = 1; cl[1] = 1; step(); quiet();
        chk("clear_over_start_cnt", 32'(bus3.cnt), 0);
        chk("clear_over_start_run", 32'(bus3.running), 0);

        // Async reset mid-run at 0x47
        st[1] = 1; lm[1] = 8'h00; step(); quiet();
        for (int n = 0; n < 200 && bus3.cnt != 8'h47; n++) step();
        chk("async_reached_47", 32'(bus3.cnt), 32'h47);
        #1 rst = 1'b1;
        #1;
        chk("async_cnt", 32'(bus3.cnt), 0);
        chk("async_running", 32'(bus3.running), 0);
        chk("async_done", 32'(bus3.done), 0);
        #1 rst = 1'b0;
        model_reset();
        repeat (5) step();
        chk("post_reset_idle_cnt", 32'(bus3.cnt), 0);

        // Randomized commands against the model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                cl[i] = ($urandom_range(0, 39) == 0);
                sp[i] = ($urandom_range(0, 14) == 0);
                st[i] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 7) == 0) lm[i] = 8'($urandom);
                else                           lm[i] = int2bcd($urandom_range(0, 20));
            end
            step();
        end
        quiet();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
